// File: rtl/gray_counter_updown.sv
// Up/down Gray-code counter with parallel load and wrap/saturate range ends.
// Optional step checker is compiled in when GRAY_CNT_CHK_EN is defined.
module gray_counter_updown #(
    parameter int SIZE     = 4,
    parameter bit SAT_MODE = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [SIZE-1:0] i_load_val,
    input  logic            i_inc,
    input  logic            i_up,
    output logic [SIZE-1:0] o_count_gray,
    output logic [SIZE-1:0] o_count_binn,
    output logic            o_at_max,
    output logic            o_at_min,
    output logic            o_wrap,
    output logic            o_err
);

    localparam logic [SIZE-1:0] MAX_VAL = '1;
    localparam logic [SIZE-1:0] MIN_VAL = '0;
    localparam logic [SIZE-1:0] ONE     = SIZE'(1);

    function automatic logic [SIZE-1:0] bin2gray(input logic [SIZE-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [SIZE-1:0] r_binn;
    logic [SIZE-1:0] r_gray;
    logic            r_at_max;
    logic            r_at_min;
    logic            r_wrap;

    logic [SIZE-1:0] w_next_binn;
    logic            w_next_wrap;

    // Load wins over a step; at a range end the step either wraps or holds.
    always_comb begin
        w_next_binn = r_binn;
        w_next_wrap = 1'b0;
        if (i_load) begin
            w_next_binn = i_load_val;
        end else if (i_inc) begin
            if (i_up) begin
                if (r_binn == MAX_VAL) begin
                    if (!SAT_MODE) begin
                        w_next_binn = MIN_VAL;
                        w_next_wrap = 1'b1;
                    end
                end else begin
                    w_next_binn = r_binn + ONE;
                end
            end else begin
                if (r_binn == MIN_VAL) begin
                    if (!SAT_MODE) begin
                        w_next_binn = MAX_VAL;
                        w_next_wrap = 1'b1;
                    end
                end else begin
                    w_next_binn = r_binn - ONE;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_binn   <= '0;
            r_gray   <= '0;
            r_at_max <= 1'b0;
            r_at_min <= 1'b1;
            r_wrap   <= 1'b0;
        end else begin
            r_binn   <= w_next_binn;
            r_gray   <= bin2gray(w_next_binn);
            r_at_max <= (w_next_binn == MAX_VAL);
            r_at_min <= (w_next_binn == MIN_VAL);
            r_wrap   <= w_next_wrap;
        end
    end

    assign o_count_binn = r_binn;
    assign o_count_gray = r_gray;
    assign o_at_max     = r_at_max;
    assign o_at_min     = r_at_min;
    assign o_wrap       = r_wrap;

`ifdef GRAY_CNT_CHK_EN
    logic [SIZE-1:0] r_chk_prev_gray;
    logic            r_chk_step;
    logic            r_chk_hold;
    logic            r_err;

    logic            w_chk_step;
    logic            w_chk_hold;
    logic [SIZE-1:0] w_chk_diff;
    logic            w_chk_multi;
    logic            w_chk_bad;

    // A saturated hold is a legitimate step that leaves Gray unchanged.
    assign w_chk_step  = i_inc && !i_load;
    assign w_chk_hold  = SAT_MODE && w_chk_step &&
                         (i_up ? (r_binn == MAX_VAL) : (r_binn == MIN_VAL));
    assign w_chk_diff  = r_gray ^ r_chk_prev_gray;
    assign w_chk_multi = (w_chk_diff & (w_chk_diff - ONE)) != '0;
    assign w_chk_bad   = r_chk_step &&
                         (((w_chk_diff == '0) && !r_chk_hold) || w_chk_multi);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chk_prev_gray <= '0;
            r_chk_step      <= 1'b0;
            r_chk_hold      <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_chk_prev_gray <= r_gray;
            r_chk_step      <= w_chk_step;
            r_chk_hold      <= w_chk_hold;
            r_err           <= r_err | w_chk_bad;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_updown.sv
// Bench for gray_counter_updown: one wrap-mode and one saturate-mode instance
// driven in lockstep, checked against a reference model through expected queues.
module tb_gray_counter_updown;

  localparam int W = 4;
  localparam int PW = 2 * W + 4;

  logic          clk = 1'b0;
  logic          rst, ld, inc, up;
  logic [W-1:0]  ld_val;

  logic [W-1:0]  gray0, binn0, gray1, binn1;
  logic          max0, min0, wrap0, err0, max1, min1, wrap1, err1;

  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];
  logic [W-1:0]  m_binn0, m_binn1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         ld;
    logic [W-1:0] val;
    logic         inc;
    logic         up;
    logic [W-1:0] exp_binn;
    logic [W-1:0] exp_gray;
    logic         exp_wrap;
  } vec_t;

  vec_t tbl[9];
  logic [W-1:0] gray_seq[17];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  gray_counter_updown #(.SIZE(W), .SAT_MODE(1'b0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_load(ld), .i_load_val(ld_val),
    .i_inc(inc), .i_up(up),
    .o_count_gray(gray0), .o_count_binn(binn0), .o_at_max(max0),
    .o_at_min(min0), .o_wrap(wrap0), .o_err(err0)
  );

  gray_counter_updown #(.SIZE(W), .SAT_MODE(1'b1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_load(ld), .i_load_val(ld_val),
    .i_inc(inc), .i_up(up),
    .o_count_gray(gray1), .o_count_binn(binn1), .o_at_max(max1),
    .o_at_min(min1), .o_wrap(wrap1), .o_err(err1)
  );

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] pack(input logic [W-1:0] b, input logic w);
    logic [W-1:0] g;
    g = b ^ (b >> 1);
    return {b, g, (b == 4'd15), (b == 4'd0), w, 1'b0};
  endfunction

  task automatic model(input bit sat, input logic r, input logic l, input logic [W-1:0] v,
                       input logic i, input logic u, input logic [W-1:0] cur,
                       output logic [W-1:0] nb, output logic w);
    nb = cur;
    w  = 1'b0;
    if (r) nb = '0;
    else if (l) nb = v;
    else if (i) begin
      if (u) begin
        if (cur == 4'd15) begin
          if (!sat) begin nb = 4'd0; w = 1'b1; end
        end else nb = cur + 4'd1;
      end else begin
        if (cur == 4'd0) begin
          if (!sat) begin nb = 4'd15; w = 1'b1; end
        end else nb = cur - 4'd1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got binn=%h gray=%h max=%b min=%b wrap=%b err=%b, expected binn=%h gray=%h max=%b min=%b wrap=%b err=%b",
               name, got[PW-1 -: W], got[W+3 -: W], got[3], got[2], got[1], got[0],
               exp[PW-1 -: W], exp[W+3 -: W], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic pop_compare(input string name);
    logic [PW-1:0] e;
    if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: expected queue empty", name);
      return;
    end
    e = exp_q0.pop_front();
    check_val({name, "_wrap"}, {binn0, gray0, max0, min0, wrap0, err0}, e);
    e = exp_q1.pop_front();
    check_val({name, "_sat"}, {binn1, gray1, max1, min1, wrap1, err1}, e);
  endtask

  // Drive one cycle; the wrap instance may take an explicit expectation from a table.
  task automatic cycle_x(input string name, input logic r, input logic l, input logic [W-1:0] v,
                         input logic i, input logic u, input bit use_tbl, input logic [PW-1:0] tbl_exp);
    logic [W-1:0] nb;
    logic w;
    rst = r; ld = l; ld_val = v; inc = i; up = u;
    model(1'b0, r, l, v, i, u, m_binn0, nb, w);
    if (use_tbl) begin
      exp_q0.push_back(tbl_exp);
      m_binn0 = tbl_exp[PW-1 -: W];
    end else begin
      exp_q0.push_back(pack(nb, w));
      m_binn0 = nb;
    end
    model(1'b1, r, l, v, i, u, m_binn1, nb, w);
    exp_q1.push_back(pack(nb, w));
    m_binn1 = nb;
    @(posedge clk);
    #1;
    pop_compare(name);
  endtask

  task automatic cycle(input string name, input logic r, input logic l, input logic [W-1:0] v,
                       input logic i, input logic u);
    cycle_x(name, r, l, v, i, u, 1'b0, '0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [PW-1:0] te;
    logic [W-1:0]  g0;
    rst = 1'b1; ld = 1'b0; ld_val = '0; inc = 1'b0; up = 1'b0;
    m_binn0 = '0; m_binn1 = '0;

    tbl[0] = '{1'b1, 4'd9,  1'b1, 1'b1, 4'd9,  4'hD, 1'b0};
    tbl[1] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd10, 4'hF, 1'b0};
    tbl[2] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd9,  4'hD, 1'b0};
    tbl[3] = '{1'b0, 4'd3,  1'b0, 1'b1, 4'd9,  4'hD, 1'b0};
    tbl[4] = '{1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 4'h8, 1'b0};
    tbl[5] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  4'h0, 1'b1};
    tbl[6] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 4'h8, 1'b1};
    tbl[7] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd15, 4'h8, 1'b0};
    tbl[8] = '{1'b1, 4'd0,  1'b1, 1'b0, 4'd0,  4'h0, 1'b0};

    gray_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // T1: reset for two cycles, with load and step asserted to show reset wins.
    cycle("t1_reset0", 1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
    cycle("t1_reset1", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    check_bit("t1_at_min", min0, 1'b1);

    // Table: load priority, steps, idle, wrap both directions.
    foreach (tbl[k]) begin
      te = {tbl[k].exp_binn, tbl[k].exp_gray, (tbl[k].exp_binn == 4'd15),
            (tbl[k].exp_binn == 4'd0), tbl[k].exp_wrap, 1'b0};
      cycle_x($sformatf("tbl%0d", k), 1'b0, tbl[k].ld, tbl[k].val, tbl[k].inc, tbl[k].up, 1'b1, te);
    end

    // T2: full upward lap in wrap mode against the literal Gray sequence.
    cycle("t2_reset", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cycle($sformatf("t2_up%0d", i), 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      checks++;
      if (gray0 !== gray_seq[i]) begin
        failures++;
        $display("FAIL t2_gray%0d: got %h expected %h", i, gray0, gray_seq[i]);
      end
      check_bit($sformatf("t2_wrap%0d", i), wrap0, (i == 16));
    end

    // T3: down step from 0.
    cycle("t3_down", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check_bit("t3_at_max", max0, 1'b1);
    cycle("t3_idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check_bit("t3_wrap_clear", wrap0, 1'b0);

    // T4: saturation at both ends.
    cycle("t4_load14", 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("t4_up%0d", i), 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      check_bit($sformatf("t4_sat_max%0d", i), (binn1 == 4'd15) && (gray1 == 4'h8) && !wrap1, 1'b1);
    end
    for (int i = 0; i < 16; i++)
      cycle($sformatf("t4_dn%0d", i), 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check_bit("t4_sat_min", min1 && (binn1 == 4'd0), 1'b1);

    // Random traffic, occasional mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      cycle("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
            W'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

`ifdef GRAY_CNT_CHK_EN
    // T6: corrupt the Gray register two bits off the previous value right after a step.
    g0 = m_binn0 ^ (m_binn0 >> 1);
    cycle("t6_step", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    inc = 1'b0;
    force u_wrap.r_gray = g0 ^ 4'b0011;
    @(posedge clk);
    #1;
    release u_wrap.r_gray;
    check_bit("t6_err_set", err0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_bit($sformatf("t6_err_hold%0d", i), err0, 1'b1);
    end
    cycle("t6_reset", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    check_bit("t6_err_clear", err0, 1'b0);
`else
    g0 = '0;
    check_bit("err_tied_low", err0 | err1 | (g0 != '0), 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
